matvec_seq_mac: RTL



---
 rtl/matvec_seq_mac.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/matvec_seq_mac.sv
// Sequential unsigned matrix-vector multiplier y = A*x using one shared MAC per clock.
// Build option: define MATVEC_SAT_EN to saturate each y element instead of truncating it.
module matvec_seq_mac #(
  parameter int ROWS  = 3,
  parameter int COLS  = 2,
  parameter int DW    = 4,
  parameter int OUT_W = 4,
  parameter int ACC_W = 2*DW + $clog2(COLS) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*COLS*DW-1:0] A,
  input  logic [COLS*DW-1:0]      x,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ROWS*OUT_W-1:0]   y,
  output logic                    busy,
  output logic [1:0]              o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE and out_valid only in DONE, so runs never overlap.

  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int JW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int AW = ROWS*COLS*DW;
  localparam int XW = COLS*DW;
  localparam int YW = ROWS*OUT_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_a;
  logic [XW-1:0]   r_x;
  logic [ACC_W-1:0] r_acc;
  logic [IW-1:0]   r_i;
  logic [JW-1:0]   r_j;
  logic [YW-1:0]   r_y;

  logic [AW-1:0]    w_a_sh;
  logic [XW-1:0]    w_x_sh;
  logic [DW-1:0]    w_a_el;
  logic [DW-1:0]    w_x_el;
  logic [2*DW-1:0]  w_prod;
  logic [ACC_W-1:0] w_sum;
  logic [OUT_W-1:0] w_red;
  logic [YW-1:0]    w_y_mask;
  logic [YW-1:0]    w_y_ins;
  logic [YW-1:0]    w_y_next;
  logic             w_last_col;
  logic             w_last_row;
  int               w_k;
  int               w_ysh;

  // Operand selection by shifting the MSB-first packed copies left.
  always_comb begin
    w_k        = int'(r_i) * COLS + int'(r_j);
    w_a_sh     = r_a << (DW * w_k);
    w_x_sh     = r_x << (DW * int'(r_j));
    w_a_el     = w_a_sh[AW-1 -: DW];
    w_x_el     = w_x_sh[XW-1 -: DW];
    w_prod     = {{DW{1'b0}}, w_a_el} * {{DW{1'b0}}, w_x_el};
    w_sum      = r_acc + ACC_W'(w_prod);
    w_last_col = (r_j == JW'(COLS-1));
    w_last_row = (r_i == IW'(ROWS-1));
`ifdef MATVEC_SAT_EN
    w_red      = ((w_sum >> OUT_W) != '0) ? '1 : OUT_W'(w_sum);
`else
    w_red      = OUT_W'(w_sum);
`endif
    w_ysh      = OUT_W * (ROWS - 1 - int'(r_i));
    w_y_mask   = YW'({OUT_W{1'b1}}) << w_ysh;
    w_y_ins    = YW'(w_red) << w_ysh;
    w_y_next   = (r_y & ~w_y_mask) | w_y_ins;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_next = S_RUN;
      S_RUN:   if (w_last_col && w_last_row) w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_x   <= '0;
      r_acc <= '0;
      r_i   <= '0;
      r_j   <= '0;
      r_y   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= A;
            r_x   <= x;
            r_acc <= '0;
            r_i   <= '0;
            r_j   <= '0;
          end
        end
        S_RUN: begin
          if (w_last_col) begin
            r_y   <= w_y_next;
            r_acc <= '0;
            r_j   <= '0;
            if (!w_last_row) r_i <= r_i + 1'b1;
          end else begin
            r_acc <= w_sum;
            r_j   <= r_j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state == S_RUN);
  assign y           = r_y;
  assign o_dbg_state = r_state;

endmodule
